// File: rtl/ahb_arbiter_kemee_pkg.sv
// Shared AHB types for the kemee arbiter: transfer/burst encodings, arbiter
// states and the fixed-burst beat-count helper.
package AHB_package;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_t;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_t;

   typedef enum logic [1:0] {
      ARB   = 2'd0,
      BURST = 2'd1,
      LOCK  = 2'd2
   } arb_state_t;

   localparam int BEAT_W = 4;

   // Number of SEQ beats that follow the NONSEQ of a fixed-length burst.
   function automatic logic [BEAT_W-1:0] burst_load(input hburst_t b);
      case (b)
         WRAP4,  INCR4:  return 4'd3;
         WRAP8,  INCR8:  return 4'd7;
         WRAP16, INCR16: return 4'd15;
         default:        return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arbiter_kemee_picker.sv
// Rotating-priority search: first requester after the current owner, owner
// last, default master when nobody requests.
module ahb_rr_picker #(
   parameter int MASTER_NUM     = 7,
   parameter int DEFAULT_MASTER = 0,
   parameter int MIDX_W         = $clog2(MASTER_NUM)
) (
   input  logic [MASTER_NUM-1:0] req_i,
   input  logic [MIDX_W-1:0]     owner_i,
   output logic [MASTER_NUM-1:0] grant_o,
   output logic [MIDX_W-1:0]     idx_o
);

   logic found;
   int   cand;

   always_comb begin
      found = 1'b0;
      cand  = 0;
      idx_o = MIDX_W'(DEFAULT_MASTER);
      for (int off = 1; off <= MASTER_NUM; off++) begin
         cand = (int'(owner_i) + off) % MASTER_NUM;
         if (!found && req_i[MIDX_W'(cand)]) begin
            found = 1'b1;
            idx_o = MIDX_W'(cand);
         end
      end
   end

   for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_onehot
      assign grant_o[gi] = (idx_o == MIDX_W'(gi));
   end

endmodule

// File: rtl/ahb_arbiter_kemee.sv
// Address-phase arbiter: round-robin grant that is frozen across fixed-length
// bursts and locked sequences, plus the lagging data-phase select.
module ahb_arbiter_kemee
   import AHB_package::*;
#(
   parameter int MASTER_NUM     = 7,
   parameter int DEFAULT_MASTER = 0,
   parameter int MIDX_W         = $clog2(MASTER_NUM)
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic [MASTER_NUM-1:0] hbusreq,
   input  logic [MASTER_NUM-1:0] hlock,
   input  logic [1:0]            htrans,
   input  logic [2:0]            hburst,
   input  logic                  hready,
   output logic [MASTER_NUM-1:0] hgrant,
   output logic [MIDX_W-1:0]     hmaster,
   output logic [MASTER_NUM-1:0] data_sel,
   output logic                  hmastlock
);

   localparam logic [MASTER_NUM-1:0] DEF_GRANT = MASTER_NUM'(1) << DEFAULT_MASTER;

   arb_state_t              state_q, state_d;
   logic [BEAT_W-1:0]       cnt_q, cnt_d;
   logic [MASTER_NUM-1:0]   hgrant_q, hgrant_d;
   logic [MIDX_W-1:0]       hmaster_q, hmaster_d;
   logic [MASTER_NUM-1:0]   data_sel_q, data_sel_d;
   logic                    hmastlock_q, hmastlock_d;

   htrans_t                 trans;
   logic [BEAT_W-1:0]       load;
   logic                    fixed_start, owner_lock, arb_ok;
   logic [MASTER_NUM-1:0]   pick_grant;
   logic [MIDX_W-1:0]       pick_idx;

   assign trans       = htrans_t'(htrans);
   assign load        = burst_load(hburst_t'(hburst));
   assign fixed_start = hready && (trans == NONSEQ) && (load != '0);
   assign owner_lock  = hlock[hmaster_q];

   ahb_rr_picker #(
      .MASTER_NUM     (MASTER_NUM),
      .DEFAULT_MASTER (DEFAULT_MASTER),
      .MIDX_W         (MIDX_W)
   ) u_picker (
      .req_i   (hbusreq),
      .owner_i (hmaster_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx)
   );

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ARB;
      else          state_q <= state_d;
   end

   // A fixed burst starting in LOCK is never an arbitration point, so a lock
   // released on a burst's NONSEQ still cannot split that burst.
   always_comb begin
      state_d = state_q;
      arb_ok  = 1'b0;
      case (state_q)
         ARB: begin
            arb_ok = hready && !fixed_start;
            if (fixed_start)             state_d = BURST;
            else if (arb_ok && owner_lock) state_d = LOCK;
         end
         BURST: begin
            arb_ok = hready && (((trans == SEQ) && (cnt_q == 4'd1)) || (trans == IDLE));
            if (arb_ok) state_d = owner_lock ? LOCK : ARB;
         end
         LOCK: begin
            if (fixed_start) state_d = BURST;
            else begin
               arb_ok = hready && !owner_lock;
               if (arb_ok) state_d = ARB;
            end
         end
         default: state_d = ARB;
      endcase
   end

   always_comb begin
      cnt_d       = cnt_q;
      hgrant_d    = hgrant_q;
      hmaster_d   = hmaster_q;
      data_sel_d  = data_sel_q;
      hmastlock_d = hmastlock_q;
      if (hready) begin
         data_sel_d = hgrant_q;
         case (trans)
            NONSEQ: begin
               cnt_d       = load;
               hmastlock_d = owner_lock;
            end
            SEQ: begin
               if (cnt_q != '0) cnt_d = cnt_q - 4'd1;
               hmastlock_d = owner_lock;
            end
            IDLE: begin
               cnt_d       = '0;
               hmastlock_d = 1'b0;
            end
            default: ;
         endcase
      end
      if (arb_ok && !owner_lock) begin
         hgrant_d  = pick_grant;
         hmaster_d = pick_idx;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         cnt_q       <= '0;
         hgrant_q    <= DEF_GRANT;
         hmaster_q   <= MIDX_W'(DEFAULT_MASTER);
         data_sel_q  <= DEF_GRANT;
         hmastlock_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         hgrant_q    <= hgrant_d;
         hmaster_q   <= hmaster_d;
         data_sel_q  <= data_sel_d;
         hmastlock_q <= hmastlock_d;
      end
   end

   assign hgrant    = hgrant_q;
   assign hmaster   = hmaster_q;
   assign data_sel  = data_sel_q;
   assign hmastlock = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter_kemee.sv
// Directed bench for ahb_arbiter_kemee: reset, round-robin, fixed burst,
// stall, lock, early IDLE and mid-burst reset, with hand-computed grants.
module tb_ahb_arbiter_kemee;

   localparam logic [1:0] T_IDLE = 2'd0, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
   localparam logic [2:0] B_SINGLE = 3'd0, B_WRAP8 = 3'd4, B_INCR4 = 3'd3,
                          B_INCR8 = 3'd5, B_INCR16 = 3'd7;

   logic       HCLK = 1'b0;
   logic       HRESETn = 1'b0;
   logic [6:0] hbusreq = '0;
   logic [6:0] hlock = '0;
   logic [1:0] htrans = T_IDLE;
   logic [2:0] hburst = B_SINGLE;
   logic       hready = 1'b1;
   logic [6:0] hgrant;
   logic [2:0] hmaster;
   logic [6:0] data_sel;
   logic       hmastlock;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_arbiter_kemee dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .htrans    (htrans),
      .hburst    (hburst),
      .hready    (hready),
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .data_sel  (data_sel),
      .hmastlock (hmastlock)
   );

   always #5 HCLK = ~HCLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   function automatic logic [6:0] oh(input int i);
      logic [6:0] v;
      v = 7'd1;
      return v << i;
   endfunction

   task automatic drive(input logic [6:0] req, input logic [6:0] lck,
                        input logic [1:0] tr, input logic [2:0] bu, input logic rdy);
      hbusreq = req;
      hlock   = lck;
      htrans  = tr;
      hburst  = bu;
      hready  = rdy;
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic expect_grant(input string tag, input int m);
      check_eq({tag, ".hgrant"}, 32'(hgrant), 32'(oh(m)));
      check_eq({tag, ".hmaster"}, 32'(hmaster), 32'(m));
   endtask

   initial begin
      // Reset
      step();
      step();
      expect_grant("reset", 0);
      check_eq("reset.data_sel", 32'(data_sel), 32'(oh(0)));
      check_eq("reset.hmastlock", 32'(hmastlock), 32'd0);
      HRESETn = 1'b1;

      // Round-robin over masters 1,2,4 starting from owner 1
      drive(7'b0000010, '0, T_IDLE, B_SINGLE, 1'b1);
      step();
      expect_grant("rr.own1", 1);
      drive(7'b0010110, '0, T_NONSEQ, B_SINGLE, 1'b1);
      step(); expect_grant("rr.g2", 2);
      step(); expect_grant("rr.g4", 4);
      check_eq("rr.data_sel", 32'(data_sel), 32'(oh(2)));
      step(); expect_grant("rr.g1", 1);
      step(); expect_grant("rr.g2b", 2);

      // Fixed INCR4 by master 3 while master 5 requests
      drive(7'b0001000, '0, T_IDLE, B_SINGLE, 1'b1);
      step(); expect_grant("fb.own3", 3);
      drive(7'b0101000, '0, T_NONSEQ, B_INCR4, 1'b1);
      step(); expect_grant("fb.nonseq", 3);
      drive(7'b0101000, '0, T_SEQ, B_INCR4, 1'b1);
      step(); expect_grant("fb.seq1", 3);
      step(); expect_grant("fb.seq2", 3);
      step(); expect_grant("fb.seq3", 5);
      check_eq("fb.data_sel_lag", 32'(data_sel), 32'(oh(3)));
      drive(7'b0100000, '0, T_IDLE, B_SINGLE, 1'b1);
      step(); expect_grant("fb.after", 5);
      check_eq("fb.data_sel", 32'(data_sel), 32'(oh(5)));

      // INCR8 by master 5 stalled for 4 cycles after 3 SEQs; master 1 waits
      drive(7'b0100010, '0, T_NONSEQ, B_INCR8, 1'b1);
      step(); expect_grant("st.nonseq", 5);
      drive(7'b0100010, '0, T_SEQ, B_INCR8, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(); expect_grant($sformatf("st.seq%0d", i + 1), 5);
      end
      for (int i = 0; i < 4; i++) begin
         if (i < 2) drive(7'b0100010, 7'b0100000, T_IDLE, B_INCR8, 1'b0);
         else       drive(7'b0100010, 7'b0100000, T_SEQ, B_INCR8, 1'b0);
         step();
         expect_grant($sformatf("st.stall%0d", i), 5);
         check_eq($sformatf("st.stall%0d.hmastlock", i), 32'(hmastlock), 32'd0);
         check_eq($sformatf("st.stall%0d.data_sel", i), 32'(data_sel), 32'(oh(5)));
      end
      drive(7'b0100010, '0, T_SEQ, B_INCR8, 1'b1);
      for (int i = 3; i < 6; i++) begin
         step(); expect_grant($sformatf("st.seq%0d", i + 1), 5);
      end
      step(); expect_grant("st.seq7", 1);
      check_eq("st.data_sel", 32'(data_sel), 32'(oh(5)));

      // Master 2 locked across two INCR4 bursts while master 6 requests
      drive(7'b0000100, '0, T_IDLE, B_SINGLE, 1'b1);
      step(); expect_grant("lk.own2", 2);
      drive(7'b1000100, 7'b0000100, T_NONSEQ, B_INCR4, 1'b1);
      step(); expect_grant("lk.b1.nonseq", 2);
      check_eq("lk.b1.hmastlock", 32'(hmastlock), 32'd1);
      drive(7'b1000100, 7'b0000100, T_SEQ, B_INCR4, 1'b1);
      for (int i = 0; i < 3; i++) begin
         step(); expect_grant($sformatf("lk.b1.seq%0d", i + 1), 2);
      end
      drive(7'b1000100, 7'b0000100, T_NONSEQ, B_INCR4, 1'b1);
      step(); expect_grant("lk.b2.nonseq", 2);
      check_eq("lk.b2.hmastlock", 32'(hmastlock), 32'd1);
      drive(7'b1000100, 7'b0000100, T_SEQ, B_INCR4, 1'b1);
      step(); expect_grant("lk.b2.seq1", 2);
      drive(7'b1000100, 7'b0000000, T_SEQ, B_INCR4, 1'b1);
      step(); expect_grant("lk.b2.seq2", 2);
      check_eq("lk.b2.unlock.hmastlock", 32'(hmastlock), 32'd0);
      step(); expect_grant("lk.b2.seq3", 6);

      // Early IDLE at beat 2 of WRAP8 with no requests
      drive(7'b1000000, '0, T_NONSEQ, B_WRAP8, 1'b1);
      step(); expect_grant("ei.nonseq", 6);
      drive(7'b1000000, '0, T_SEQ, B_WRAP8, 1'b1);
      step(); expect_grant("ei.seq1", 6);
      drive(7'b0000000, '0, T_IDLE, B_WRAP8, 1'b1);
      step(); expect_grant("ei.idle", 0);
      drive(7'b0001000, '0, T_IDLE, B_SINGLE, 1'b1);
      step(); expect_grant("ei.arb", 3);

      // Reset asserted mid INCR16 of locked master 3
      drive(7'b0001010, 7'b0001000, T_NONSEQ, B_INCR16, 1'b1);
      step(); expect_grant("rs.nonseq", 3);
      drive(7'b0001010, 7'b0001000, T_SEQ, B_INCR16, 1'b1);
      step();
      check_eq("rs.pre.hmastlock", 32'(hmastlock), 32'd1);
      HRESETn = 1'b0;
      #2;
      expect_grant("rs.async", 0);
      check_eq("rs.async.data_sel", 32'(data_sel), 32'(oh(0)));
      check_eq("rs.async.hmastlock", 32'(hmastlock), 32'd0);
      HRESETn = 1'b1;
      drive(7'b0000010, '0, T_IDLE, B_SINGLE, 1'b1);
      step(); expect_grant("rs.arb", 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_arbiter_kemee.md
# ahb_arbiter_kemee

Address-phase arbiter for the kemee master-side interconnect. It produces the one-hot select vectors that drive the master-side payload mux: `hgrant` for the address/control payload and `data_sel` for the write-data payload, which lags by one accepted phase. It resolves requests from up to `MASTER_NUM` masters round-robin. It never breaks a fixed-length burst or a locked sequence.

## Interface
- `MASTER_NUM`, default 7: number of masters; equals the master mux `CHANNEL_NUM`.
- `DEFAULT_MASTER`, default 0: master granted when nobody requests.
- `MIDX_W`, default `$clog2(MASTER_NUM)`: width of the master index.

Ports:
- `HCLK` in, 1: single clock, rising edge.
- `HRESETn` in, 1: reset, asynchronous, active-low.
- `hbusreq` in, `MASTER_NUM`: per-master bus request.
- `hlock` in, `MASTER_NUM`: per-master lock request.
- `htrans` in, 2: transfer type on the muxed address bus.
- `hburst` in, 3: burst type on the muxed address bus.
- `hready` in, 1: global ready; a phase is accepted when it is 1.
- `hgrant` out, `MASTER_NUM`: one-hot address-phase select.
- `hmaster` out, `MIDX_W`: index of the granted master.
- `data_sel` out, `MASTER_NUM`: one-hot data-phase select.
- `hmastlock` out, 1: the current data phase is locked.

## Operation
States:
- ARB: grant may move.
- BURST: fixed-length burst in progress; grant frozen.
- LOCK: owner holds `hlock`; grant frozen.

Beat counter:
- 4 bits.
- Loaded on an accepted NONSEQ (`htrans`=2 and `hready`=1): INCR4/WRAP4 load 3, INCR8/WRAP8 load 7, INCR16/WRAP16 load 15. SINGLE and INCR load 0.
- Decrements on each accepted SEQ (`htrans`=3).
- Holds on BUSY (`htrans`=1).

Arbitration point (`arb_ok`) is `hready`=1 and one of the following holds:
- state is ARB and the accepted transfer does not start a fixed burst;
- state is BURST and an accepted SEQ takes the counter from 1 to 0;
- state is BURST and `htrans`=IDLE is accepted (early termination: counter cleared);
- state is LOCK and `hlock[hmaster]`=0.

Transitions:
- ARB → BURST on an accepted NONSEQ with a nonzero load.
- ARB → LOCK when `hlock[hmaster]`=1 at `arb_ok`.
- BURST/LOCK → ARB at `arb_ok`.
- BURST takes priority over LOCK. A locked fixed burst returns to LOCK, not ARB, when it ends with `hlock` still high.

Selection at `arb_ok`:
- If the owner has `hlock`=1, keep the owner.
- Otherwise search `hbusreq` starting at index `(hmaster+1) mod MASTER_NUM` and wrapping. The first set bit wins.
- The owner is checked last, so it is regranted only if it is the sole requester.
- No request: grant `DEFAULT_MASTER`.

Outputs:
- `hgrant` and `hmaster` are registered and always consistent. `hgrant` is exactly one-hot, never zero.
- `data_sel` is loaded from `hgrant` when `hready`=1, otherwise held.
- `hmastlock` is loaded from `hlock[hmaster]` when `hready`=1 and `htrans` is NONSEQ or SEQ. It is cleared on an accepted IDLE.

Reset values: `hgrant` = one-hot(`DEFAULT_MASTER`), `hmaster`=`DEFAULT_MASTER`, `data_sel`=`hgrant`, `hmastlock`=0, state ARB, counter 0.

## Timing
- Grant latency is 1 cycle: a request sampled at an `arb_ok` edge appears on `hgrant` after that edge.
- `hready`=0 freezes all registers, including the counter and state.
- `data_sel` trails `hgrant` by exactly one accepted phase.
- Asserting `HRESETn` mid-burst immediately forces the reset values. No partial burst state survives.
- Simultaneous last-beat SEQ and new requests: rearbitrate on that same edge, so the new master's NONSEQ follows the last beat with no bubble.

## Structure
- `AHB_package` holds:
  - `htrans_t` enum: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3;
  - `hburst_t` enum: SINGLE=0, INCR=1, WRAP4=2, INCR4=3, WRAP8=4, INCR8=5, WRAP16=6, INCR16=7;
  - `arb_state_t`: ARB, BURST, LOCK.
- One sub-module, `ahb_rr_picker`: combinational rotate-priority search taking `hbusreq` and `hmaster` and returning the next one-hot grant.

## Test plan
- **Reset:** `DEFAULT_MASTER`=0, `HRESETn` low → `hgrant`=7'b0000001, `hmaster`=0, `data_sel`=7'b0000001, `hmastlock`=0.
- **Round-robin:** `hbusreq`=7'b0010110, owner 1, SINGLE transfers with `hready`=1 → grants 2, 4, 1, 2 on consecutive edges.
- **Fixed burst:** master 3 issues INCR4 while master 5 requests → grant stays 3 through 3 SEQs. Grant moves to 5 on the edge accepting the last SEQ. `data_sel`=5 one accepted cycle later.
- **Stall:** `hready`=0 for 4 cycles mid-INCR8 → counter, state and all outputs unchanged. The burst resumes and ends after 7 accepted SEQs.
- **Lock:** master 2 holds `hlock`=1 across two INCR4 bursts while master 6 requests → grant stays 2 and `hmastlock`=1. Grant moves to 6 at the first `arb_ok` after `hlock` drops.
- **Early IDLE / no requests:** IDLE accepted at beat 2 of WRAP8 with `hbusreq`=0 → state ARB, `hgrant`=one-hot(0). Also `HRESETn` pulsed mid-burst → reset values.
